idex_stage_reg: RTL and testbench
=================================

# idex_stage_reg

Parametrised ID/EX pipeline stage register with valid/ready flow control, a one-entry skid buffer, synchronous flush and bubble insertion. It sits between the decode stage (register file read, sign extension, control unit) and the execute stage. It replaces a free-running capture register with one that can stall, drain and squash without losing or duplicating instructions.

## Interface
- DATA_W, 32, width of read_data1/read_data2/sign_ex
- REG_W, 5, width of register specifiers rs/rt/rd
- ALUOP_W, 3, width of alu_op
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle; in_fire = in_valid & in_ready
- flush  in  1  synchronous squash of all held entries and same-cycle input
- in_reg_write, in_mem_to_reg, in_mem_read, in_mem_write, in_reg_dst, in_alu_src  in  1 each  control bits
- in_alu_op  in  ALUOP_W  ALU operation
- in_read_data1, in_read_data2, in_sign_ex  in  DATA_W each  operands
- in_rs, in_rt, in_rd  in  REG_W each  register specifiers
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute consumes; out_fire = out_valid & out_ready
- out_* (one per in_* above)  out  same widths  registered copies
- load_use_stall  out  1  hazard indicator (see Configuration)

## Operation
- Storage: main entry (drives out_*) and skid entry. States: EMPTY (none valid), ONE (main only), FULL (main + skid).
- in_ready = !skid_valid & !rst & !load_use_stall.
- EMPTY: in_fire -> main<=in, ONE.
- ONE: in_fire & out_fire -> main<=in, ONE; in_fire & !out_fire -> skid<=in, FULL; !in_fire & out_fire -> EMPTY; else hold.
- FULL: in_ready=0; out_fire -> main<=skid, ONE; else hold.
- flush (priority over all transitions): next state EMPTY; any same-cycle in_fire discarded; out_fire that cycle still counts as consumed.
- Bubble rule: whenever main is invalid, out control bits (reg_write, mem_to_reg, mem_read, mem_write, reg_dst, alu_src, alu_op) read 0. Data/specifier outputs hold last value.
- No reordering, duplication or loss: out sequence equals accepted-and-unflushed input sequence.

## Timing
- Reset: out_valid=0, in_ready=0, all out_* = 0, skid invalid, state EMPTY; in_ready=1 in the first cycle after rst deasserts.
- Latency: in_fire in EMPTY -> out_valid=1 with data on the next rising edge.
- Throughput: one instruction per cycle while out_ready=1.
- in_ready depends only on registered state, except the load_use_stall term.
- rst mid-operation: entries dropped immediately, no completion of partial transfers.
- Simultaneous in_fire, out_fire and flush: result EMPTY.

## Configuration
- IDEX_HAZARD_DETECT_EN defined: load_use_stall = out_valid & out_mem_read & in_valid & (out_rt != 0) & (out_rt == in_rs | out_rt == in_rt). It is combinational, and while it is high in_ready=0. Decode must hold its instruction until the load leaves main.
- Undefined: load_use_stall tied 0. Hazard handling is external. Ports are unchanged.

## Test plan
- Reset then stream 4 instructions (rs=1..4, in_read_data1=0x10..0x13) with out_ready=1 -> out_valid from cycle 1, outputs 0x10..0x13 in order, in_ready stays 1.
- Stream with out_ready=0 for 3 cycles -> accept 2 entries, in_ready=0 on the 3rd cycle. Release out_ready -> both entries emerge in order, nothing lost.
- FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, out_mem_write=0, out_reg_write=0, in_ready=1, flushed input never appears.
- Assert rst asynchronously mid-stream, between edges -> out_valid and all out_* go to 0 immediately, without waiting for clk.
- With IDEX_HAZARD_DETECT_EN: main holds lw with rt=5, incoming rs=5 -> load_use_stall=1, in_ready=0. After out_fire, the instruction is accepted next cycle. Same scenario with rt=0 -> no stall.
- Without the macro, same lw/rs=5 scenario -> load_use_stall=0, instruction accepted back-to-back.

Source files
------------

// File: rtl/idex_stage_reg_if.sv
// ID/EX stage bundle: valid/ready handshake plus decoded control, operands and specifiers.
// master drives valid and payload, slave drives ready.
interface idex_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3
);
  logic               valid;
  logic               ready;
  logic               reg_write;
  logic               mem_to_reg;
  logic               mem_read;
  logic               mem_write;
  logic               reg_dst;
  logic               alu_src;
  logic [ALUOP_W-1:0] alu_op;
  logic [DATA_W-1:0]  read_data1;
  logic [DATA_W-1:0]  read_data2;
  logic [DATA_W-1:0]  sign_ex;
  logic [REG_W-1:0]   rs;
  logic [REG_W-1:0]   rt;
  logic [REG_W-1:0]   rd;

  modport master (
    output valid,
    output reg_write, mem_to_reg, mem_read,
    output mem_write, reg_dst, alu_src, alu_op,
    output read_data1, read_data2, sign_ex,
    output rs, rt, rd,
    input  ready
  );

  modport slave (
    input  valid,
    input  reg_write, mem_to_reg, mem_read,
    input  mem_write, reg_dst, alu_src, alu_op,
    input  read_data1, read_data2, sign_ex,
    input  rs, rt, rd,
    output ready
  );
endinterface

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with one-entry skid buffer, flush and bubble insertion.
// Optional load-use hazard detection: define IDEX_HAZARD_DETECT_EN.
module idex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  idex_stage_reg_if.slave  in_bus,
  idex_stage_reg_if.master out_bus,
  output logic load_use_stall
);

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [DATA_W-1:0]  read_data1;
    logic [DATA_W-1:0]  read_data2;
    logic [DATA_W-1:0]  sign_ex;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t state;
  state_t state_nx;

  ent_t main_q;
  ent_t skid_q;
  ent_t in_ent;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;
  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  assign in_ent.reg_write  = in_bus.reg_write;
  assign in_ent.mem_to_reg = in_bus.mem_to_reg;
  assign in_ent.mem_read   = in_bus.mem_read;
  assign in_ent.mem_write  = in_bus.mem_write;
  assign in_ent.reg_dst    = in_bus.reg_dst;
  assign in_ent.alu_src    = in_bus.alu_src;
  assign in_ent.alu_op     = in_bus.alu_op;
  assign in_ent.read_data1 = in_bus.read_data1;
  assign in_ent.read_data2 = in_bus.read_data2;
  assign in_ent.sign_ex    = in_bus.sign_ex;
  assign in_ent.rs         = in_bus.rs;
  assign in_ent.rt         = in_bus.rt;
  assign in_ent.rd         = in_bus.rd;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);

`ifdef IDEX_HAZARD_DETECT_EN
  // Load in main whose destination feeds the incoming instruction.
  assign load_use_stall = main_valid & main_q.mem_read
                        & in_bus.valid
                        & (main_q.rt != '0)
                        & ((main_q.rt == in_bus.rs)
                        |  (main_q.rt == in_bus.rt));
`else
  assign load_use_stall = 1'b0;
`endif

  assign in_bus.ready = !skid_valid & !rst & !load_use_stall;
  assign in_fire      = in_bus.valid & in_bus.ready;
  assign out_fire     = main_valid & out_bus.ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          ld_main_in = 1'b1;
          state_nx   = ONE;
        end
      end
      ONE: begin
        unique case (1'b1)
          in_fire && out_fire: begin
            ld_main_in = 1'b1;
          end
          in_fire && !out_fire: begin
            ld_skid  = 1'b1;
            state_nx = FULL;
          end
          !in_fire && out_fire: begin
            state_nx = EMPTY;
          end
          default: begin
          end
        endcase
      end
      FULL: begin
        if (out_fire) begin
          ld_main_skid = 1'b1;
          state_nx     = ONE;
        end
      end
      default: begin
        state_nx = EMPTY;
      end
    endcase
    // Squash wins: no loads, so data outputs keep their last value.
    if (flush) begin
      state_nx     = EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_q <= in_ent;
      end else if (ld_main_skid) begin
        main_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_ent;
      end
    end
  end

  assign out_bus.valid      = main_valid;
  assign out_bus.reg_write  = main_valid & main_q.reg_write;
  assign out_bus.mem_to_reg = main_valid & main_q.mem_to_reg;
  assign out_bus.mem_read   = main_valid & main_q.mem_read;
  assign out_bus.mem_write  = main_valid & main_q.mem_write;
  assign out_bus.reg_dst    = main_valid & main_q.reg_dst;
  assign out_bus.alu_src    = main_valid & main_q.alu_src;
  assign out_bus.alu_op     = main_valid ? main_q.alu_op : '0;
  assign out_bus.read_data1 = main_q.read_data1;
  assign out_bus.read_data2 = main_q.read_data2;
  assign out_bus.sign_ex    = main_q.sign_ex;
  assign out_bus.rs         = main_q.rs;
  assign out_bus.rt         = main_q.rt;
  assign out_bus.rd         = main_q.rd;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: vector table, hand sequences, random vs queue model.
// Hazard expectations follow IDEX_HAZARD_DETECT_EN.
module tb_idex_stage_reg;

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
    logic        rdst;
    logic        asrc;
    logic [2:0]  aop;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] sx;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ent_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] d1;
    logic        ov;
    logic        ir;
    logic [31:0] ed1;
  } vec_t;

  logic clk;
  logic rst;
  logic flush;
  logic lus;
  int   checks;
  int   errors;

  idex_stage_reg_if #(.DATA_W(32), .REG_W(5), .ALUOP_W(3)) ib ();
  idex_stage_reg_if #(.DATA_W(32), .REG_W(5), .ALUOP_W(3)) ob ();

  idex_stage_reg #(.DATA_W(32), .REG_W(5), .ALUOP_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_bus(ib),
    .out_bus(ob),
    .load_use_stall(lus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input ent_t e);
    ib.valid      = v;
    ib.reg_write  = e.rw;
    ib.mem_to_reg = e.m2r;
    ib.mem_read   = e.mr;
    ib.mem_write  = e.mw;
    ib.reg_dst    = e.rdst;
    ib.alu_src    = e.asrc;
    ib.alu_op     = e.aop;
    ib.read_data1 = e.d1;
    ib.read_data2 = e.d2;
    ib.sign_ex    = e.sx;
    ib.rs         = e.rs;
    ib.rt         = e.rt;
    ib.rd         = e.rd;
  endtask

  function automatic ent_t get_out();
    ent_t e;
    e.rw   = ob.reg_write;
    e.m2r  = ob.mem_to_reg;
    e.mr   = ob.mem_read;
    e.mw   = ob.mem_write;
    e.rdst = ob.reg_dst;
    e.asrc = ob.alu_src;
    e.aop  = ob.alu_op;
    e.d1   = ob.read_data1;
    e.d2   = ob.read_data2;
    e.sx   = ob.sign_ex;
    e.rs   = ob.rs;
    e.rt   = ob.rt;
    e.rd   = ob.rd;
    return e;
  endfunction

  function automatic ent_t mk(input logic [31:0] d1, input logic [4:0] rs,
                              input logic [4:0] rt, input logic mr);
    ent_t e;
    e    = '0;
    e.rw = 1'b1;
    e.mw = !mr;
    e.mr = mr;
    e.d1 = d1;
    e.rs = rs;
    e.rt = rt;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.rw   = 1'($urandom);
    e.m2r  = 1'($urandom);
    e.mr   = 1'($urandom);
    e.mw   = 1'($urandom);
    e.rdst = 1'($urandom);
    e.asrc = 1'($urandom);
    e.aop  = 3'($urandom);
    e.d1   = $urandom;
    e.d2   = $urandom;
    e.sx   = $urandom;
    e.rs   = 5'($urandom_range(0, 7));
    e.rt   = 5'($urandom_range(0, 7));
    e.rd   = 5'($urandom);
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0);
    ob.ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t        tbl[$];
  ent_t        q[$];
  ent_t        last_head;
  ent_t        cur;
  ent_t        expv;
  logic        hz;
  logic        stall_e;
  logic        ready_e;
  logic        iv;
  logic        inf;
  logic        outf;
  logic        hold;

  task automatic addv(input logic iv_, input logic ordy, input logic fl,
                      input logic [31:0] d1, input logic ov,
                      input logic ir, input logic [31:0] ed1);
    vec_t v;
    v.iv = iv_; v.ordy = ordy; v.fl = fl; v.d1 = d1;
    v.ov = ov;  v.ir = ir;     v.ed1 = ed1;
    tbl.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef IDEX_HAZARD_DETECT_EN
    hz = 1'b1;
`else
    hz = 1'b0;
`endif
    // iv ordy fl d1 | ov ir ed1
    addv(1, 1, 0, 32'h10, 0, 1, 32'h00);
    addv(1, 1, 0, 32'h11, 1, 1, 32'h10);
    addv(1, 1, 0, 32'h12, 1, 1, 32'h11);
    addv(1, 1, 0, 32'h13, 1, 1, 32'h12);
    addv(0, 1, 0, 32'h00, 1, 1, 32'h13);
    addv(0, 1, 0, 32'h00, 0, 1, 32'h13);
    addv(1, 0, 0, 32'h14, 0, 1, 32'h13);
    addv(1, 0, 0, 32'h15, 1, 1, 32'h14);
    addv(1, 0, 0, 32'h16, 1, 0, 32'h14);
    addv(1, 1, 0, 32'h16, 1, 0, 32'h14);
    addv(1, 1, 0, 32'h16, 1, 1, 32'h15);
    addv(0, 1, 0, 32'h00, 1, 1, 32'h16);
    addv(0, 1, 0, 32'h00, 0, 1, 32'h16);
    addv(1, 0, 0, 32'h17, 0, 1, 32'h16);
    addv(1, 0, 0, 32'h18, 1, 1, 32'h17);
    addv(1, 0, 1, 32'h19, 1, 0, 32'h17);
    addv(1, 1, 0, 32'h1a, 0, 1, 32'h17);
    addv(0, 1, 0, 32'h00, 1, 1, 32'h1a);
    addv(0, 1, 0, 32'h00, 0, 1, 32'h1a);
    addv(1, 1, 0, 32'h1b, 0, 1, 32'h1a);
    addv(1, 1, 1, 32'h1c, 1, 1, 32'h1b);
    addv(0, 1, 0, 32'h00, 0, 1, 32'h1b);

    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0);
    ob.ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_out", get_out(), '0);
    chk("reset_valid", ob.valid, 0);
    chk("reset_ready", ib.ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].iv, mk(tbl[i].d1, tbl[i].d1[4:0] - 5'h0f, 5'd0, 1'b0));
      ob.ready = tbl[i].ordy;
      flush = tbl[i].fl;
      #4;
      chk($sformatf("tbl%0d_valid", i), ob.valid, tbl[i].ov);
      chk($sformatf("tbl%0d_ready", i), ib.ready, tbl[i].ir);
      chk($sformatf("tbl%0d_d1", i), ob.read_data1, tbl[i].ed1);
      chk($sformatf("tbl%0d_ctrl", i), {ob.reg_write, ob.mem_write},
          {tbl[i].ov, tbl[i].ov});
      @(posedge clk);
      #1;
    end
    flush = 1'b0;

    // Async reset between edges while FULL.
    drive(1'b1, mk(32'h20, 5'd1, 5'd0, 1'b0));
    ob.ready = 1'b0;
    @(posedge clk);
    #1 drive(1'b1, mk(32'h21, 5'd2, 5'd0, 1'b0));
    @(posedge clk);
    #1 drive(1'b0, '0);
    #2;
    chk("pre_arst_valid", ob.valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", ob.valid, 0);
    chk("arst_ready", ib.ready, 0);
    chk("arst_out", get_out(), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    ob.ready = 1'b1;
    #4;
    chk("post_arst_valid", ob.valid, 0);
    chk("post_arst_ready", ib.ready, 1);
    @(posedge clk);
    #1;

    // Load-use: lw rt=5 followed by dependent rs=5.
    drive(1'b1, mk(32'h30, 5'd1, 5'd5, 1'b1));
    @(posedge clk);
    #1 drive(1'b1, mk(32'h31, 5'd5, 5'd2, 1'b0));
    #4;
    chk("lu_stall", lus, hz);
    chk("lu_ready", ib.ready, !hz);
    chk("lu_head", ob.read_data1, 32'h30);
    @(posedge clk);
    #1;
    if (hz) begin
      #4;
      chk("lu2_stall", lus, 0);
      chk("lu2_ready", ib.ready, 1);
      chk("lu2_valid", ob.valid, 0);
      @(posedge clk);
      #1;
    end
    drive(1'b0, '0);
    #4;
    chk("lu_dep_valid", ob.valid, 1);
    chk("lu_dep_d1", ob.read_data1, 32'h31);
    @(posedge clk);
    #1;

    // Same with rt=0: never a hazard.
    drive(1'b1, mk(32'h40, 5'd1, 5'd0, 1'b1));
    @(posedge clk);
    #1 drive(1'b1, mk(32'h41, 5'd0, 5'd0, 1'b0));
    #4;
    chk("lu0_stall", lus, 0);
    chk("lu0_ready", ib.ready, 1);
    @(posedge clk);
    #1 drive(1'b0, '0);
    #4;
    chk("lu0_dep_d1", ob.read_data1, 32'h41);
    @(posedge clk);
    #1;

    // Random traffic against a two-deep FIFO model.
    do_reset();
    q.delete();
    last_head = '0;
    hold = 1'b0;
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) cur = rnd_ent();
      iv = hold | ($urandom_range(0, 9) < 7);
      drive(iv, cur);
      ob.ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 19) == 0);
      #4;
      stall_e = hz && q.size() > 0 && q[0].mr && iv && q[0].rt != 0
                && (q[0].rt == cur.rs || q[0].rt == cur.rt);
      ready_e = (q.size() < 2) && !stall_e;
      if (q.size() > 0) begin
        expv = q[0];
      end else begin
        expv = last_head;
        {expv.rw, expv.m2r, expv.mr, expv.mw} = '0;
        {expv.rdst, expv.asrc, expv.aop} = '0;
      end
      chk("rnd_valid", ob.valid, q.size() > 0);
      chk("rnd_ready", ib.ready, ready_e);
      chk("rnd_stall", lus, stall_e);
      chk("rnd_out", get_out(), expv);
      inf = iv && ready_e;
      outf = (q.size() > 0) && ob.ready;
      hold = iv && !inf;
      @(posedge clk);
      #1;
      if (flush) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(cur);
      end
      if (q.size() > 0) last_head = q[0];
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
